// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// constants_pkg / bus_arbiter
//
// Purpose:
//   Round-robin arbiter that shares the 16-bit CPU command/data bus among the
//   four bus units (ALU, REGFILE, DEBUG, STACK). It grants one unit at a time.
//   It force-releases an owner that holds the bus for TIMEOUT_CYCLES cycles.
//   It flags stray release pulses and timeouts as ERROR_INVALID_INPUT.
//
// Parameters:
//   NUM_REQ        number of requesters; index 0..3 -> ALU, REGFILE, DEBUG, STACK
//   TIMEOUT_CYCLES maximum cycles a grant may be held; legal range 2..255
//
// Ports:
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous, active-low reset
//   req       in   per-unit level-sensitive bus request
//   done      in   per-unit release pulse
//   grant     out  one-hot bus grant (registered)
//   grant_id  out  unit_id_t of the current owner, ID_NONE when idle
//   bus_busy  out  high while any grant is active
//   error     out  error_t, one-cycle ERROR_INVALID_INPUT pulse
// ---------------------------------------------------------------------------
package constants_pkg;
  localparam int COMMAND_WIDTH = 4;
  localparam int ERROR_WIDTH   = 4;

  typedef enum logic [COMMAND_WIDTH-1:0] {
    ID_NONE    = 4'h0,
    ID_ALU     = 4'h1,
    ID_REGFILE = 4'h2,
    ID_DEBUG   = 4'h3,
    ID_STACK   = 4'h4
  } unit_id_t;

  typedef enum logic [ERROR_WIDTH-1:0] {
    ERROR_NONE          = 4'h0,
    ERROR_INVALID_INPUT = 4'hF
  } error_t;
endpackage

module bus_arbiter
  import constants_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       grant,
  output logic [COMMAND_WIDTH-1:0] grant_id,
  output logic                     bus_busy,
  output logic [ERROR_WIDTH-1:0]   error
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [7:0]       hold_cnt;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  int               cand;

  logic             owner_release;
  logic             stray_done;
  logic             hold_expired;

  function automatic unit_id_t idx_to_id(input logic [IDX_W-1:0] idx);
    case (int'(idx))
      0:       return ID_ALU;
      1:       return ID_REGFILE;
      2:       return ID_DEBUG;
      default: return ID_STACK;
    endcase
  endfunction

  // Round-robin search starting just after the last owner, wrapping around.
  // The last owner itself is checked last, so it only wins when alone.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last;
    cand       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // The registered one-hot grant doubles as the owner mask. In IDLE it is
  // zero, so every done bit is stray there as well.
  assign owner_release = (|(done & grant)) | ~(|(req & grant));
  assign stray_done    = |(done & ~grant);
  assign hold_expired  = (hold_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Arbiter FSM with all outputs registered. A timeout only raises an error
  // when the owner did not release in that same cycle. A stray done and a
  // timeout in the same cycle merge into one error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= ID_NONE;
      bus_busy <= 1'b0;
      error    <= ERROR_NONE;
      hold_cnt <= '0;
      last     <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          error <= stray_done ? ERROR_INVALID_INPUT : ERROR_NONE;
          if (pick_valid) begin
            grant    <= NUM_REQ'(1) << pick_idx;
            grant_id <= idx_to_id(pick_idx);
            bus_busy <= 1'b1;
            last     <= pick_idx;
            hold_cnt <= '0;
            state    <= GRANTED;
          end
        end
        GRANTED: begin
          error <= (stray_done || (hold_expired && !owner_release)) ?
                   ERROR_INVALID_INPUT : ERROR_NONE;
          if (owner_release || hold_expired) begin
            grant    <= '0;
            grant_id <= ID_NONE;
            bus_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
